// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory boot bank.
package imem_pkg;

    typedef enum logic {
        IMEM_IDLE = 1'b0,
        IMEM_LOAD = 1'b1
    } imem_state_t;

    // addi x0,x0,0 : the canonical RISC-V NOP
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    function automatic int bytes_per_word(input int instr_w);
        return instr_w / 8;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into instruction words.
// word/word_valid are combinational so the caller can write the word on the
// same cycle its last byte is accepted.
module imem_byte_packer
    import imem_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [7:0]         byte_in,
    input  logic               byte_en,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    localparam int BPW   = bytes_per_word(INSTR_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

    logic [CNT_W-1:0] cnt;

    assign word_valid = byte_en && (cnt == LAST);

    // Byte position within the current word; restarts on clear or after the last byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_en) begin
            cnt <= word_valid ? '0 : cnt + 1'b1;
        end
    end

    generate
        if (BPW > 1) begin : g_multi
            logic [INSTR_W-9:0] shreg;

            // New byte enters at the top; earlier bytes drift down toward bit 0
            assign word = {byte_in, shreg};

            // Partial-word holding register, data only so no reset
            always_ff @(posedge clk) begin
                if (byte_en) begin
                    shreg <= word[INSTR_W-1:8];
                end
            end
        end else begin : g_single
            assign word = byte_in;
        end
    endgenerate

endmodule

// File: rtl/imem_boot_bank.sv
// Instruction memory with byte-serial boot loader and one-cycle fetch port.
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// entry and report mismatches on fetch_perr.
module imem_boot_bank
    import imem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int INSTR_W = 32,
    parameter int AW      = $clog2(DEPTH),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic [AW:0]        load_words,
    input  logic [7:0]         ld_byte,
    input  logic               ld_valid,
    output logic               ld_ready,
    output logic               load_busy,
    output logic               load_done,
`ifdef IMEM_PARITY_EN
    output logic               fetch_perr,
`endif
    input  logic               fetch_req,
    input  logic [31:0]        fetch_addr,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               fetch_valid,
    output logic               fetch_stall,
    output logic               fetch_misal
);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif

    imem_state_t        state;
    logic [AW:0]        words_total;
    logic [AW:0]        words_done;
    logic [INSTR_W-1:0] pk_word;
    logic               pk_valid;
    logic               byte_acc;
    logic               pk_clear;
    logic [MEM_W-1:0]   mem [DEPTH];
    logic [MEM_W-1:0]   wr_entry;
    logic [MEM_W-1:0]   rd_entry;
    logic [AW-1:0]      fetch_idx;
    logic               serve;
    logic               unused_addr_bits;

    assign byte_acc = ld_valid && ld_ready;
    assign pk_clear = load_start && (state == IMEM_IDLE);

    imem_byte_packer #(
        .INSTR_W (INSTR_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .byte_in    (ld_byte),
        .byte_en    (byte_acc),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // Loader FSM: counts completed words and drives the registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IMEM_IDLE;
            ld_ready    <= 1'b0;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            words_total <= '0;
            words_done  <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IMEM_IDLE: begin
                    if (load_start) begin
                        words_done <= '0;
                        if (load_words == '0) begin
                            load_done <= 1'b1;
                        end else begin
                            words_total <= load_words;
                            state       <= IMEM_LOAD;
                            ld_ready    <= 1'b1;
                            load_busy   <= 1'b1;
                        end
                    end
                end
                IMEM_LOAD: begin
                    if (pk_valid) begin
                        words_done <= words_done + 1'b1;
                        if (words_done == words_total - 1'b1) begin
                            state     <= IMEM_IDLE;
                            ld_ready  <= 1'b0;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: state <= IMEM_IDLE;
            endcase
        end
    end

`ifdef IMEM_PARITY_EN
    assign wr_entry = {^pk_word, pk_word};
`else
    assign wr_entry = pk_word;
`endif

    // Image write port; the low AW bits of the word count wrap the index for oversize images
    always_ff @(posedge clk) begin
        if (pk_valid) begin
            mem[words_done[AW-1:0]] <= wr_entry;
        end
    end

    // Upper PC bits beyond the array are deliberately ignored so addresses alias
    assign fetch_idx        = fetch_addr[AW+1:2];
    assign unused_addr_bits = ^fetch_addr[31:AW+2];
    assign rd_entry         = mem[fetch_idx];
    assign serve            = fetch_req && !load_busy;

    // Registered fetch response; refused requests return NOP with a stall flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_stall <= 1'b0;
            fetch_misal <= 1'b0;
            fetch_instr <= NOP_INSTR;
`ifdef IMEM_PARITY_EN
            fetch_perr  <= 1'b0;
`endif
        end else begin
            fetch_valid <= serve;
            fetch_stall <= fetch_req && load_busy;
            fetch_misal <= serve && (fetch_addr[1:0] != 2'b00);
            fetch_instr <= serve ? rd_entry[INSTR_W-1:0] : NOP_INSTR;
`ifdef IMEM_PARITY_EN
            fetch_perr  <= serve && (^rd_entry);
`endif
        end
    end

endmodule
